// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB-Lite encodings and arbiter state type used by the bus arbiter slice.
// burstBeats() gives the number of beats after the NONSEQ for a fixed-length burst.
package ahb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } ahbTransferEnum;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } ahbBurstEnum;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_LOCKED = 2'd3
    } ahbArbStateEnum;

    localparam int BEAT_W = 5;

    // Undefined-length INCR counts like SINGLE: every beat is an arbitration point.
    function automatic logic [BEAT_W-1:0] burstBeats(input ahbBurstEnum burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd7;
            HBURST_WRAP16, HBURST_INCR16: return 5'd15;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_priority_picker.sv
// Combinational round-robin find-first: searches req starting one above ptr,
// wrapping, and reports the first requester (ptr itself is checked last).
module ahb_rr_priority_picker #(
    parameter int NO_OF_MASTERS = 4,
    parameter int HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS)
) (
    input  logic [NO_OF_MASTERS-1:0] req,
    input  logic [HMASTER_WIDTH-1:0] ptr,
    output logic                     valid,
    output logic [HMASTER_WIDTH-1:0] idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 1; i <= NO_OF_MASTERS; i++) begin
            cand = (int'(ptr) + i) % NO_OF_MASTERS;
            if (!valid && req[cand[HMASTER_WIDTH-1:0]]) begin
                valid = 1'b1;
                idx   = cand[HMASTER_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter: owns hgrant, the address-phase owner (hmaster)
// and the data-phase owner (hmasterData); never splits fixed bursts or locked sequences.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NO_OF_MASTERS  = 4,
    parameter int HMASTER_WIDTH  = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NO_OF_MASTERS-1:0] hbusreq,
    input  logic [NO_OF_MASTERS-1:0] hlock,
    input  ahbTransferEnum           htrans,
    input  ahbBurstEnum              hburst,
    input  logic                     hready,
    output logic [NO_OF_MASTERS-1:0] hgrant,
    output logic [HMASTER_WIDTH-1:0] hmaster,
    output logic [HMASTER_WIDTH-1:0] hmasterData,
    output logic                     hmastlock
);

    localparam logic [HMASTER_WIDTH-1:0] DEF_IDX   = HMASTER_WIDTH'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

    ahbArbStateEnum           state_q, state_d;
    logic [BEAT_W-1:0]        beats_q, beats_d;
    logic [HMASTER_WIDTH-1:0] rr_q, rr_d;
    logic [HMASTER_WIDTH-1:0] owner_q, owner_d;
    logic                     accepted, arb_point, hold_lock;
    logic                     pick_valid;
    logic [HMASTER_WIDTH-1:0] pick_idx;

    ahb_rr_priority_picker #(
        .NO_OF_MASTERS(NO_OF_MASTERS),
        .HMASTER_WIDTH(HMASTER_WIDTH)
    ) u_picker (
        .req  (hbusreq),
        .ptr  (rr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // Remaining-beat count after this edge; hready=0 leaves it untouched.
    always_comb begin
        beats_d = beats_q;
        if (hready) begin
            case (htrans)
                HTRANS_NONSEQ: beats_d = burstBeats(hburst);
                HTRANS_SEQ:    beats_d = (beats_q == '0) ? '0 : beats_q - 1'b1;
                HTRANS_BUSY:   beats_d = beats_q;
                default:       beats_d = '0;
            endcase
        end
    end

    assign accepted  = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign arb_point = hready && (htrans == HTRANS_IDLE || (accepted && beats_d == '0));
    assign hold_lock = hlock[owner_q] && hbusreq[owner_q];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ARB_IDLE;
        end else if (hready) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arb_point) begin
            if (hold_lock)       state_d = ARB_LOCKED;
            else if (pick_valid) state_d = ARB_OWNED;
            else                 state_d = ARB_IDLE;
        end else if (beats_d != '0 && state_q != ARB_LOCKED) begin
            state_d = ARB_BURST;
        end
    end

    // Grant selection: a locked owner that still requests keeps the bus.
    always_comb begin
        owner_d = owner_q;
        rr_d    = rr_q;
        if (arb_point && !hold_lock) begin
            if (pick_valid) begin
                owner_d = pick_idx;
                rr_d    = pick_idx;
            end else begin
                owner_d = DEF_IDX;
            end
        end
    end

    // hmaster trails the grant by one accepted cycle, hmasterData trails hmaster.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            beats_q     <= '0;
            rr_q        <= DEF_IDX;
            owner_q     <= DEF_IDX;
            hgrant      <= DEF_GRANT;
            hmaster     <= DEF_IDX;
            hmasterData <= DEF_IDX;
            hmastlock   <= 1'b0;
        end else if (hready) begin
            beats_q     <= beats_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            hgrant      <= NO_OF_MASTERS'(1) << owner_d;
            hmaster     <= owner_q;
            hmasterData <= hmaster;
            hmastlock   <= hlock[owner_q];
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios then randomized traffic,
// each cycle's expectation produced by a behavioural model and checked by a monitor.
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int DEF = 0;

    logic           hclk    = 1'b0;
    logic           hreset  = 1'b1;
    logic [N-1:0]   hbusreq = '0;
    logic [N-1:0]   hlock   = '0;
    ahbTransferEnum htrans  = HTRANS_IDLE;
    ahbBurstEnum    hburst  = HBURST_SINGLE;
    logic           hready  = 1'b1;
    logic [N-1:0]   hgrant;
    logic [W-1:0]   hmaster;
    logic [W-1:0]   hmasterData;
    logic           hmastlock;

    ahb_bus_arbiter #(
        .NO_OF_MASTERS (N),
        .HMASTER_WIDTH (W),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hbusreq    (hbusreq),
        .hlock      (hlock),
        .htrans     (htrans),
        .hburst     (hburst),
        .hready     (hready),
        .hgrant     (hgrant),
        .hmaster    (hmaster),
        .hmasterData(hmasterData),
        .hmastlock  (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] m;
        logic [W-1:0] md;
        logic         ml;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the bus, who owns each phase, beats still owed.
    int m_owner = DEF, m_rr = DEF, m_beats = 0, m_hm = DEF, m_hmd = DEF;
    bit m_hml = 1'b0;
    int burst_len[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    task automatic model_step();
        int nb;
        int new_owner;
        int c;
        bit ap;
        if (hreset) begin
            m_owner = DEF; m_rr = DEF; m_beats = 0;
            m_hm = DEF; m_hmd = DEF; m_hml = 1'b0;
        end else if (hready) begin
            case (htrans)
                HTRANS_NONSEQ: nb = burst_len[hburst] - 1;
                HTRANS_SEQ:    nb = (m_beats > 0) ? m_beats - 1 : 0;
                HTRANS_BUSY:   nb = m_beats;
                default:       nb = 0;
            endcase
            ap = (htrans == HTRANS_IDLE) ||
                 ((htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && nb == 0);
            new_owner = m_owner;
            if (ap && !(hlock[m_owner[W-1:0]] && hbusreq[m_owner[W-1:0]])) begin
                new_owner = DEF;
                for (int k = 1; k <= N; k++) begin
                    c = (m_rr + k) % N;
                    if (hbusreq[c[W-1:0]]) begin
                        new_owner = c;
                        m_rr = c;
                        break;
                    end
                end
            end
            m_hmd   = m_hm;
            m_hm    = m_owner;
            m_hml   = hlock[m_owner[W-1:0]];
            m_owner = new_owner;
            m_beats = nb;
        end
        exp_q.push_back('{g: N'(1) << m_owner, m: W'(m_hm), md: W'(m_hmd), ml: m_hml});
    endtask

    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lock,
                       input ahbTransferEnum tr, input ahbBurstEnum bu,
                       input logic rdy, input logic rst);
        @(negedge hclk);
        hbusreq = req;
        hlock   = lock;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        hreset  = rst;
        model_step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge that has a pending expectation is checked after settling.
    exp_t e;
    initial begin
        forever begin
            @(posedge hclk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hgrant",      32'(hgrant),      32'(e.g));
                chk("hmaster",     32'(hmaster),     32'(e.m));
                chk("hmasterData", 32'(hmasterData), 32'(e.md));
                chk("hmastlock",   32'(hmastlock),   32'(e.ml));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    logic [N-1:0]   r_req, r_lock;
    ahbTransferEnum r_tr;
    ahbBurstEnum    r_bu;
    logic           r_rdy, r_rst;
    int             r;

    initial begin
        // Reset held with everyone requesting
        repeat (2) cyc(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b1);

        // Round robin with SINGLE transfers
        repeat (6) cyc(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);

        // INCR8 owned by master 0 with two BUSY cycles
        cyc(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cyc(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, 1'b0);
        cyc(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b0);
        repeat (2) cyc(4'b0011, 4'b0000, HTRANS_BUSY, HBURST_INCR8, 1'b1, 1'b0);
        repeat (6) cyc(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b0);

        // WRAP4 with wait states on the last beat
        cyc(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1, 1'b0);
        repeat (2) cyc(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP4, 1'b1, 1'b0);
        repeat (3) cyc(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP4, 1'b0, 1'b0);
        cyc(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP4, 1'b1, 1'b0);

        // Locked pair of INCR4 from master 2
        cyc(4'b0100, 4'b0100, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        repeat (2) begin
            cyc(4'b0101, 4'b0100, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 1'b0);
            repeat (3) cyc(4'b0101, 4'b0100, HTRANS_SEQ, HBURST_INCR4, 1'b1, 1'b0);
        end
        cyc(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cyc(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);

        // Nobody requesting, then INCR16 terminated early by IDLE
        repeat (2) cyc(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, 1'b0);
        repeat (4) cyc(4'b0010, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_INCR16, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);

        // Reset in the middle of a burst
        cyc(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, 1'b0);
        cyc(4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b0);
        cyc(4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b1);
        cyc(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);

        // Randomized traffic shaped loosely like a real bus
        for (int n = 0; n < 3000; n++) begin
            r_req  = 4'($urandom);
            r_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_rst  = ($urandom_range(0, 249) == 0);
            r_bu   = ahbBurstEnum'(3'($urandom_range(0, 7)));
            r      = $urandom_range(0, 9);
            if (m_beats > 0)
                r_tr = (r < 7) ? HTRANS_SEQ : (r < 9) ? HTRANS_BUSY : HTRANS_IDLE;
            else if (r < 6)
                r_tr = HTRANS_NONSEQ;
            else if (r < 9)
                r_tr = HTRANS_IDLE;
            else
                r_tr = ahbTransferEnum'(2'($urandom));
            cyc(r_req, r_lock, r_tr, r_bu, r_rdy, r_rst);
        end

        @(posedge hclk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin arbiter sharing one AHB-Lite address/data path between NO_OF_MASTERS requesting masters.
- Owns the grant vector, HMASTER (address-phase owner) and the data-phase owner index that drives the HWDATA/HRDATA steering mux.
- Never splits a fixed-length burst or a locked sequence.
- Sits between master agents and the interconnect mux/decoder.

Parameters:
- NO_OF_MASTERS, 4: number of requesters, 2..16.
- HMASTER_WIDTH, (NO_OF_MASTERS==1)?1:$clog2(NO_OF_MASTERS): master index width.
- DEFAULT_MASTER, 0: master granted when nobody requests. Must be < NO_OF_MASTERS.

Ports:
- hclk  in  1  bus clock, all state on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NO_OF_MASTERS  per-master bus request.
- hlock  in  NO_OF_MASTERS  per-master locked-sequence request.
- htrans  in  2  muxed HTRANS of the current address owner (ahbTransferEnum).
- hburst  in  3  muxed HBURST of the current address owner (ahbBurstEnum).
- hready  in  1  combined transfer-completion.
- hgrant  out  NO_OF_MASTERS  one-hot grant, registered.
- hmaster  out  HMASTER_WIDTH  address-phase owner index.
- hmasterData  out  HMASTER_WIDTH  data-phase owner index.
- hmastlock  out  1  address phase belongs to a locked sequence.

Behaviour:
Interface rule:
- One clock, hclk. Reset hreset is synchronous and active-high.

Reset values:
- hgrant = one-hot(DEFAULT_MASTER); hmaster = hmasterData = DEFAULT_MASTER.
- hmastlock = 0; state = ARB_IDLE; beatsLeft = 0; rrPtr = DEFAULT_MASTER.
- Reset asserted mid-burst aborts the burst and returns to these values next edge.

Accepted phase:
- An address phase is accepted on an edge with hready=1 and htrans is NONSEQ or SEQ.

Beat counter (5 bits):
- Accepted NONSEQ: beatsLeft loads 3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16, 0 for SINGLE/INCR.
- Accepted SEQ: decrements, saturating at 0.
- BUSY: holds.
- IDLE with hready=1: clears to 0 (early termination; also covers an ERROR-abort).

States:
- ARB_IDLE: no hbusreq; DEFAULT_MASTER granted.
- ARB_OWNED: owner granted, no burst in progress.
- ARB_BURST: beatsLeft>0.
- ARB_LOCKED: owner's hlock=1 at the last arbitration point.

Arbitration point (hready=1 and one of):
- htrans=IDLE;
- an accepted phase leaving beatsLeft==0 after update (last beat of a fixed burst, any SINGLE, any INCR beat).
- Never during BUSY.
- Never while the next beatsLeft>0.

Selection at an arbitration point:
- If the owner's hlock=1 and hbusreq=1: keep the grant, go to ARB_LOCKED.
- Otherwise scan from (rrPtr+1) mod NO_OF_MASTERS upward, wrapping; grant the first requester and set rrPtr to it.
- If no requester: grant DEFAULT_MASTER, go to ARB_IDLE.
- If the only requester is the current owner: it retains the grant.

Timing:
- hgrant updates on the arbitration-point edge.
- hmaster <= index(hgrant) on every edge with hready=1, so the new owner drives its first address one cycle after the grant.
- hmasterData <= hmaster on every edge with hready=1.
- hmastlock <= hlock[index(hgrant)] on every edge with hready=1.
- hready=0 freezes hgrant, hmaster, hmasterData, hmastlock, beatsLeft and rrPtr.
- Request changes while not at an arbitration point are ignored until the next one.
- A deasserted hbusreq from the owner mid-burst does not end the burst.

Decomposition:
- AhbGlobalPackage: ahbBurstEnum and ahbTransferEnum (already present), a new ahbArbStateEnum {ARB_IDLE, ARB_OWNED, ARB_BURST, ARB_LOCKED}, and a burstBeats(ahbBurstEnum) function returning beat count minus one.
- Sub-module ahb_rr_priority_picker: combinational round-robin find-first given request vector and pointer, returning a valid flag and an index.

Test Plan:
1. Reset: hreset=1 for 2 cycles with hbusreq=4'b1111 -> hgrant=4'b0001, hmaster=0, hmastlock=0 throughout reset.
2. Round robin: hbusreq=4'b1111, each master issues SINGLE, hready=1 -> grant order 1,2,3,0,1; hmaster trails hgrant by 1 cycle; hmasterData trails hmaster by 1.
3. INCR8 with hbusreq=4'b0011 and master 0 owning:
   - with 2 BUSY cycles inserted, no grant change until the 8th accepted beat;
   - hgrant becomes 4'b0010 on that edge.
4. Wait states: hready=0 for 3 cycles on the last beat of WRAP4 -> hgrant/hmaster frozen; handover on the edge where hready returns to 1.
5. Lock: master 2 with hlock=1, hbusreq=4'b0101, two back-to-back INCR4 -> master 0 not granted until hlock[2]=0 at an arbitration point; hmastlock=1 for all 8 beats.
6. Idle/early termination: hbusreq=0 -> hgrant=4'b0001 (DEFAULT_MASTER). Separately, during INCR16 at beat 5, htrans=IDLE -> beatsLeft=0 and re-arbitration the same edge.
